// File: rtl/divu_p4d2_seq.sv
// divu_p4d2_seq: sequential unsigned restoring divider.
// Divides a P_WIDTH dividend by a D_WIDTH divisor, retiring one quotient bit
// per clock under a start/rdy handshake. The quotient and remainder are
// registered and change only when a result completes.
// Optional feature macro: DIVU_DIV0_FLAG_EN adds the div0 port. With the macro,
// a zero divisor short-circuits to DONE one edge after accept.
module divu_p4d2_seq #(
    parameter int P_WIDTH = 4,
    parameter int D_WIDTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [P_WIDTH-1:0] p,
    input  logic [D_WIDTH-1:0] d,
    output logic               busy,
    output logic               rdy,
    output logic [P_WIDTH-1:0] q,
`ifdef DIVU_DIV0_FLAG_EN
    output logic [D_WIDTH-1:0] r,
    output logic               div0
`else
    output logic [D_WIDTH-1:0] r
`endif
);

    localparam int CNT_W = $clog2(P_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [P_WIDTH-1:0] p_work;
    logic [D_WIDTH-1:0] d_reg;
    logic [D_WIDTH:0]   rem;
    logic [P_WIDTH-1:0] q_work;
    logic [CNT_W-1:0]   cnt;

    logic [D_WIDTH:0]   rem_shift;
    logic [D_WIDTH:0]   d_ext;
    logic [D_WIDTH:0]   rem_next;
    logic [P_WIDTH-1:0] q_next;
    logic               take;

    // One restoring step: bring in the next dividend bit, subtract when it fits
    always_comb begin
        rem_shift = {rem[D_WIDTH-1:0], p_work[P_WIDTH-1]};
        d_ext     = {1'b0, d_reg};
        take      = (rem_shift >= d_ext);
        rem_next  = take ? (rem_shift - d_ext) : rem_shift;
        q_next    = {q_work[P_WIDTH-2:0], take};
    end

    // Control FSM, datapath registers and registered result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            p_work <= '0;
            d_reg  <= '0;
            rem    <= '0;
            q_work <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            rdy    <= 1'b0;
            q      <= '0;
            r      <= '0;
`ifdef DIVU_DIV0_FLAG_EN
            div0   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        p_work <= p;
                        d_reg  <= d;
                        rem    <= '0;
                        q_work <= '0;
                        cnt    <= CNT_W'(P_WIDTH);
                        busy   <= 1'b1;
                        rdy    <= 1'b0;
                        state  <= RUN;
`ifdef DIVU_DIV0_FLAG_EN
                        div0   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    p_work <= {p_work[P_WIDTH-2:0], 1'b0};
                    rem    <= rem_next;
                    q_work <= q_next;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        q     <= q_next;
                        r     <= rem_next[D_WIDTH-1:0];
                        state <= DONE;
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                    end
`ifdef DIVU_DIV0_FLAG_EN
                    // p_work is still unshifted on the first RUN edge, so its low bits are the dividend's
                    if (d_reg == '0) begin
                        q     <= '1;
                        r     <= p_work[D_WIDTH-1:0];
                        div0  <= 1'b1;
                        state <= DONE;
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
